// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port scheduler: FSM state encoding
// and the default guard length and clear word.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_SCAN,
        ST_DRAIN,
        ST_IDLE
    } fb_state_t;

    localparam int unsigned FB_GUARD   = 4;
    localparam logic [5:0]  FB_INITIAL = 6'b111111;

endpackage

// File: rtl/fb_clear_counter.sv
// Framebuffer clear sweep: address counter 0..RAMLENGTH-1 advancing one word
// per enable tick while running, with a combinational last-address flag.
module fb_clear_counter #(
    parameter int unsigned RAMLENGTH  = 800,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  restart,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAMLENGTH - 1);

    assign done = run && (addr == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (enable) begin
            if (restart) begin
                addr <= '0;
            end else if (run) begin
                addr <= (addr == LAST) ? '0 : addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_port_scheduler.sv
// Arbitrates the framebuffer port between clear sweep, scan-out and FIFO drain.
// Optional statistics outputs are enabled by defining FB_SCHED_STATS_EN.
module fb_port_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned          X_WIRE_WIDTH = 10,
    parameter int unsigned          Y_WIRE_WIDTH = 10,
    parameter int unsigned          RAMLENGTH    = 800,
    parameter int unsigned          ADDR_WIDTH   = 10,
    parameter int unsigned          DATA_WIDTH   = 6,
    parameter logic [DATA_WIDTH-1:0] INITIAL     = DATA_WIDTH'(FB_INITIAL),
    parameter int unsigned          H_TOTAL      = 800,
    parameter int unsigned          GUARD        = FB_GUARD
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    display_on,
    input  logic [X_WIRE_WIDTH-1:0] hpos,
    input  logic [Y_WIRE_WIDTH-1:0] vpos,
    input  logic                    clr_req,
    input  logic                    fifo_empty,
    input  logic [X_WIRE_WIDTH-1:0] fifo_hpos,
    input  logic [Y_WIRE_WIDTH-1:0] fifo_vpos,
    input  logic [2:0]              fifo_rgb,
    output logic                    fifo_pop,
    output logic [X_WIRE_WIDTH-1:0] fb_hpos,
    output logic [Y_WIRE_WIDTH-1:0] fb_vpos,
    output logic [2:0]              fb_rgb_wr,
    output logic                    fb_we,
    output logic                    clr_we,
    output logic [ADDR_WIDTH-1:0]   clr_addr,
    output logic [DATA_WIDTH-1:0]   clr_data,
    output logic                    clr_busy
`ifdef FB_SCHED_STATS_EN
    ,
    output logic [15:0]             drain_count,
    output logic                    stall_flag
`endif
);

    localparam logic [X_WIRE_WIDTH-1:0] GUARD_START = X_WIRE_WIDTH'(H_TOTAL - GUARD);

    fb_state_t state;
    logic      draining;
    logic      window_open;
    logic      clr_done;

    fb_clear_counter #(
        .RAMLENGTH (RAMLENGTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .restart(clr_req),
        .run    (state == ST_CLEAR),
        .addr   (clr_addr),
        .done   (clr_done)
    );

    // DRAIN means "a pop was issued on the previous enable tick": the FIFO head
    // now holds that pixel and this tick's write commits it.
    assign draining    = (state == ST_DRAIN);
    assign window_open = (hpos < GUARD_START);

    assign fifo_pop = reset_n && enable && !clr_req && !display_on && !fifo_empty
                      && window_open && (state == ST_IDLE || state == ST_DRAIN);
    assign fb_we     = reset_n && enable && draining;
    assign fb_hpos   = draining ? fifo_hpos : hpos;
    assign fb_vpos   = draining ? fifo_vpos : vpos;
    assign fb_rgb_wr = draining ? fifo_rgb : '0;

    assign clr_we   = reset_n && enable && (state == ST_CLEAR);
    assign clr_data = INITIAL;
    assign clr_busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
        end else if (enable) begin
            if (clr_req) begin
                state <= ST_CLEAR;
            end else begin
                case (state)
                    ST_CLEAR: if (clr_done) state <= display_on ? ST_SCAN : ST_IDLE;
                    ST_SCAN:  if (!display_on) state <= ST_IDLE;
                    ST_IDLE, ST_DRAIN: begin
                        if (display_on)    state <= ST_SCAN;
                        else if (fifo_pop) state <= ST_DRAIN;
                        else               state <= ST_IDLE;
                    end
                    default:  state <= ST_CLEAR;
                endcase
            end
        end
    end

`ifdef FB_SCHED_STATS_EN
    logic [15:0]             frame_cnt;
    logic [Y_WIRE_WIDTH-1:0] vpos_q;
    logic                    frame_end;

    assign frame_end = (vpos == '0) && (vpos_q != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            vpos_q      <= '0;
            drain_count <= '0;
            stall_flag  <= 1'b0;
        end else if (enable) begin
            vpos_q <= vpos;
            if (frame_end) begin
                drain_count <= frame_cnt + 16'(fb_we);
                frame_cnt   <= '0;
                stall_flag  <= !fifo_empty;
            end else begin
                frame_cnt <= frame_cnt + 16'(fb_we);
            end
        end
    end
`endif

endmodule
